multi_rate_divider: RTL

- Parametrised, multi-channel successor to the single-channel rate divider.
- Each channel is an independent programmable down-counter with its own period. Each channel supports periodic or one-shot mode, start/stop/pause control, a registered single-cycle tick and a wrapping tick counter.
- Used as the shared timebase for note scrolling, beat detection and display refresh in the game datapath, all on the system clock.

---
 rtl/multi_rate_divider.sv | 75 +++++++
 1 files changed

// File: rtl/multi_rate_divider.sv
// Multi-channel programmable rate divider: one down-counter per channel with
// periodic/one-shot modes, start/stop/pause control, tick pulse and tick counter.
module multi_rate_divider #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 28,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS-1:0]             stop,
  input  logic [CHANNELS-1:0]             enable,
  input  logic [CHANNELS-1:0]             one_shot,
  input  logic [CHANNELS*WIDTH-1:0]       divide_by,
  output logic [CHANNELS-1:0]             tick,
  output logic [CHANNELS-1:0]             busy,
  output logic [CHANNELS*COUNT_WIDTH-1:0] tick_count
);

  // state | meaning
  // IDLE  | counter parked at 0, waiting for start; tick_count keeps last value
  // RUN   | counting down; reloads (periodic) or returns to IDLE (one-shot)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [0:0]             state_q;
    logic [WIDTH-1:0]       cnt_q;
    logic                   tick_q;
    logic [COUNT_WIDTH-1:0] tc_q;
    logic [WIDTH-1:0]       period;

    assign period = divide_by[g*WIDTH +: WIDTH];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        tc_q    <= '0;
      end else if (state_q == ST_IDLE) begin
        tick_q <= 1'b0;
        if (start[g]) begin
          cnt_q   <= period;
          tc_q    <= '0;
          state_q <= ST_RUN;
        end
      end else if (stop[g]) begin
        // stop beats a simultaneous start and suppresses a pending terminal tick
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        tick_q  <= 1'b0;
      end else if (start[g]) begin
        cnt_q  <= period;
        tc_q   <= '0;
        tick_q <= 1'b0;
      end else if (!enable[g]) begin
        tick_q <= 1'b0;
      end else if (cnt_q == '0) begin
        tick_q <= 1'b1;
        tc_q   <= tc_q + COUNT_WIDTH'(1);
        if (one_shot[g]) state_q <= ST_IDLE;
        else             cnt_q   <= period;
      end else begin
        cnt_q  <= cnt_q - WIDTH'(1);
        tick_q <= 1'b0;
      end
    end

    assign tick[g]                              = tick_q;
    assign busy[g]                              = (state_q == ST_RUN);
    assign tick_count[g*COUNT_WIDTH +: COUNT_WIDTH] = tc_q;
  end

endmodule
